// File: rtl/viterbi_pkg.sv
// Shared Viterbi definitions: default widths, trellis state codes and the
// serializer FSM encoding.
package viterbi_pkg;

   localparam int DEF_MET_W    = 4;
   localparam int DEF_PATH_W   = 8;
   localparam int DEF_PTR_W    = 3;
   localparam int DEF_LAST_PTR = 7;

   typedef enum logic [1:0] {
      S00 = 2'b00,
      S01 = 2'b01,
      S10 = 2'b10,
      S11 = 2'b11
   } state_code_t;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

endpackage

// File: rtl/survivor_output_serializer_min4_select.sv
// Combinational minimum-of-four path-metric selector. Ties resolve to the lowest
// state index. The winning metric port exists only when BEST_METRIC_OUT_EN is defined.
module min4_select
   import viterbi_pkg::*;
#(
   parameter int MET_W = DEF_MET_W
) (
   input  logic [MET_W-1:0] metric_00,
   input  logic [MET_W-1:0] metric_01,
   input  logic [MET_W-1:0] metric_10,
   input  logic [MET_W-1:0] metric_11,
   output logic [1:0]       win_idx
`ifdef BEST_METRIC_OUT_EN
   ,
   output logic [MET_W-1:0] win_metric
`endif
);

   logic             lo_pick;
   logic             hi_pick;
   logic [MET_W-1:0] lo_metric;
   logic [MET_W-1:0] hi_metric;
   logic             hi_wins;

   // Strict less-than at every node keeps ties on the lower index.
   always_comb begin
      lo_pick   = metric_01 < metric_00;
      lo_metric = lo_pick ? metric_01 : metric_00;
      hi_pick   = metric_11 < metric_10;
      hi_metric = hi_pick ? metric_11 : metric_10;
      hi_wins   = hi_metric < lo_metric;
      win_idx   = hi_wins ? {1'b1, hi_pick} : {1'b0, lo_pick};
   end

`ifdef BEST_METRIC_OUT_EN
   assign win_metric = hi_wins ? hi_metric : lo_metric;
`endif

endmodule

// File: rtl/survivor_output_serializer.sv
// Captures the best survivor of each completed ACS frame into a one-frame hold
// buffer and shifts it out MSB first over valid/ready. Optional macro: BEST_METRIC_OUT_EN.
module survivor_output_serializer
   import viterbi_pkg::*;
#(
   parameter int MET_W    = DEF_MET_W,
   parameter int PATH_W   = DEF_PATH_W,
   parameter int PTR_W    = DEF_PTR_W,
   parameter int LAST_PTR = DEF_LAST_PTR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic [PTR_W-1:0]  write_pointer,
   input  logic [MET_W-1:0]  new_branch_metric_00,
   input  logic [MET_W-1:0]  new_branch_metric_01,
   input  logic [MET_W-1:0]  new_branch_metric_10,
   input  logic [MET_W-1:0]  new_branch_metric_11,
   input  logic [PATH_W-1:0] selected_branch_at_00,
   input  logic [PATH_W-1:0] selected_branch_at_01,
   input  logic [PATH_W-1:0] selected_branch_at_10,
   input  logic [PATH_W-1:0] selected_branch_at_11,
   output logic              bit_out,
   output logic              bit_valid,
   input  logic              bit_ready,
   output logic              frame_last,
   output logic              busy,
   output logic              overflow
`ifdef BEST_METRIC_OUT_EN
   ,
   output logic [1:0]        best_state,
   output logic [MET_W-1:0]  best_metric
`endif
);

   localparam int CNT_W = (PATH_W > 1) ? $clog2(PATH_W) : 1;

   logic [1:0]        win_idx;
   logic [PATH_W-1:0] win_path;
   logic [PATH_W-1:0] hold_path;
   logic [PATH_W-1:0] shreg;
   logic              hold_full;
   logic [CNT_W-1:0]  cnt;
   logic [0:0]        state;
   logic              capture;
   logic              handshake;
   logic              last_bit;
   logic              drain;

`ifdef BEST_METRIC_OUT_EN
   logic [MET_W-1:0]  win_metric;
   logic [1:0]        hold_state;
   logic [MET_W-1:0]  hold_metric;
`endif

   min4_select #(.MET_W(MET_W)) u_min4 (
      .metric_00 (new_branch_metric_00),
      .metric_01 (new_branch_metric_01),
      .metric_10 (new_branch_metric_10),
      .metric_11 (new_branch_metric_11),
      .win_idx   (win_idx)
`ifdef BEST_METRIC_OUT_EN
      ,
      .win_metric(win_metric)
`endif
   );

   always_comb begin
      win_path = selected_branch_at_00;
      case (win_idx)
         S01:     win_path = selected_branch_at_01;
         S10:     win_path = selected_branch_at_10;
         S11:     win_path = selected_branch_at_11;
         default: win_path = selected_branch_at_00;
      endcase
   end

   // drain marks the cycle in which the hold buffer moves into shreg, which
   // frees it for a capture arriving in that same cycle.
   assign capture   = valid_in && (write_pointer == PTR_W'(LAST_PTR));
   assign handshake = (state == SHIFT) && bit_ready;
   assign last_bit  = (cnt == CNT_W'(PATH_W - 1));
   assign drain     = hold_full && ((state == IDLE) || (handshake && last_bit));

   assign bit_valid  = (state == SHIFT);
   assign bit_out    = (state == SHIFT) && shreg[PATH_W-1];
   assign frame_last = (state == SHIFT) && last_bit;
   assign busy       = (state != IDLE) || hold_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_full <= 1'b0;
         hold_path <= '0;
         shreg     <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
      end else begin
         if (capture) begin
            if (!hold_full || drain) begin
               hold_path <= win_path;
               hold_full <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (drain) begin
            hold_full <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (hold_full) begin
                  shreg <= hold_path;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (handshake) begin
                  if (last_bit) begin
                     cnt <= '0;
                     if (hold_full) begin
                        shreg <= hold_path;
                     end else begin
                        shreg <= '0;
                        state <= IDLE;
                     end
                  end else begin
                     shreg <= shreg << 1;
                     cnt   <= cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BEST_METRIC_OUT_EN
   // State/metric tags ride through the hold buffer in lockstep with the survivor.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_state  <= '0;
         hold_metric <= '0;
         best_state  <= '0;
         best_metric <= '0;
      end else begin
         if (capture && (!hold_full || drain)) begin
            hold_state  <= win_idx;
            hold_metric <= win_metric;
         end
         if (drain) begin
            best_state  <= hold_state;
            best_metric <= hold_metric;
         end
      end
   end
`endif

endmodule
